// File: rtl/debounce_pkg.sv
// debounce_pkg: shared types and default constants for the debounce scheduler.
//   state_e       - scheduler FSM state encoding
//   DefaultSettle - default number of stable cycles before a key change commits
//   DefaultCntW   - default settle-timer width
package debounce_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StSettle,
    StCommit
  } state_e;

  localparam int unsigned DefaultSettle = 4;
  localparam int unsigned DefaultCntW   = 17;

endpackage

// File: rtl/debounce_sched_settle_timer.sv
// settle_timer: shared settle counter for the debounce scheduler.
//   ck    - clock, rising edge
//   reset - asynchronous active-low reset
//   clr   - synchronous clear to 0 (takes effect on the next edge)
//   hit   - high while the count equals SETTLE
// The count increments every cycle and saturates at SETTLE.
module settle_timer #(
  parameter int unsigned SETTLE = debounce_pkg::DefaultSettle,
  parameter int unsigned CNT_W  = debounce_pkg::DefaultCntW
) (
  input  logic ck,
  input  logic reset,
  input  logic clr,
  output logic hit
);

  localparam logic [CNT_W-1:0] SettleVal = CNT_W'(SETTLE);

  logic [CNT_W-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (count_q != SettleVal) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign hit = (count_q == SettleVal);

endmodule

// File: rtl/debounce_sched.sv
// debounce_sched: debounces N_KEYS raw keys with a single shared settle timer.
// Keys that disagree with their committed level are served one at a time in
// round-robin order starting at ptr.
//   ck    - clock, rising edge
//   reset - asynchronous active-low reset
//   keys  - raw, bouncing key levels
//   level - debounced key levels (registered)
//   pulse - one-cycle press strobe, at most one bit set (registered)
//   busy  - high whenever the FSM is not idle
// Build option: define DEBOUNCE_SYNC_EN to pass each key through a 2-flop
// synchronizer before comparison (adds 2 cycles of latency).
module debounce_sched
  import debounce_pkg::*;
#(
  parameter int unsigned N_KEYS = 4,
  parameter int unsigned SETTLE = DefaultSettle,
  parameter int unsigned CNT_W  = DefaultCntW
) (
  input  logic              ck,
  input  logic              reset,
  input  logic [N_KEYS-1:0] keys,
  output logic [N_KEYS-1:0] level,
  output logic [N_KEYS-1:0] pulse,
  output logic              busy
);

  localparam int unsigned PtrW = (N_KEYS > 1) ? $clog2(N_KEYS) : 1;

  logic [N_KEYS-1:0] keys_s;

`ifdef DEBOUNCE_SYNC_EN
  logic [N_KEYS-1:0] sync1_q, sync2_q;

  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= keys;
      sync2_q <= sync1_q;
    end
  end

  assign keys_s = sync2_q;
`else
  assign keys_s = keys;
`endif

  state_e            state_d, state_q;
  logic [PtrW-1:0]   sel_d, sel_q;
  logic [PtrW-1:0]   ptr_d, ptr_q;
  logic [N_KEYS-1:0] level_d, level_q;
  logic [N_KEYS-1:0] pulse_d, pulse_q;
  logic [N_KEYS-1:0] mismatch;
  logic [PtrW-1:0]   pick;
  logic              found;
  logic              clr;
  logic              hit;

  assign mismatch = keys_s ^ level_q;

  // Round-robin search: first mismatching key at ptr, ptr+1, ... mod N_KEYS.
  always_comb begin
    logic [PtrW-1:0] cand;
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int unsigned off = 0; off < N_KEYS; off++) begin
      cand = PtrW'((32'(ptr_q) + off) % N_KEYS);
      if (!found && mismatch[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    level_d = level_q;
    pulse_d = '0;
    clr     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          sel_d   = pick;
          state_d = StArm;
        end
      end
      StArm: begin
        clr     = 1'b1;
        state_d = StSettle;
      end
      StSettle: begin
        // Bounce back wins over a simultaneous timer hit.
        if (keys_s[sel_q] == level_q[sel_q]) begin
          state_d = StIdle;
        end else if (hit) begin
          state_d        = StCommit;
          level_d[sel_q] = ~level_q[sel_q];
          // Strobe only on press (new level 1), never on release.
          pulse_d[sel_q] = ~level_q[sel_q];
        end
      end
      StCommit: begin
        if (32'(sel_q) == N_KEYS - 1) begin
          ptr_d = '0;
        end else begin
          ptr_d = sel_q + PtrW'(1);
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      sel_q   <= '0;
      ptr_q   <= '0;
      level_q <= '0;
      pulse_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  settle_timer #(
    .SETTLE(SETTLE),
    .CNT_W (CNT_W)
  ) u_settle_timer (
    .ck   (ck),
    .reset(reset),
    .clr  (clr),
    .hit  (hit)
  );

  assign level = level_q;
  assign pulse = pulse_q;
  assign busy  = (state_q != StIdle);

endmodule

// File: tb/tb_debounce_sched.sv
// tb_debounce_sched: directed bench for debounce_sched (N_KEYS=4, SETTLE=4).
// Expected pulses (cycle, vector) are queued when keys are driven and checked
// by a monitor on the falling edge. Honors DEBOUNCE_SYNC_EN for latency.
module tb_debounce_sched;

  localparam int unsigned NK = 4;
  localparam int unsigned ST = 4;
`ifdef DEBOUNCE_SYNC_EN
  localparam int Lat = ST + 5;
`else
  localparam int Lat = ST + 3;
`endif
  // Spacing between back-to-back commits of already-pending keys.
  localparam int Gap = ST + 4;

  typedef struct {
    int         cyc;
    logic [3:0] vec;
  } exp_t;

  logic          ck = 1'b0;
  logic          reset;
  logic [NK-1:0] keys;
  logic [NK-1:0] level;
  logic [NK-1:0] pulse;
  logic          busy;

  exp_t sb[$];
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;

  always #5 ck = ~ck;
  always @(posedge ck) cyc <= cyc + 1;

  debounce_sched #(
    .N_KEYS(NK),
    .SETTLE(ST),
    .CNT_W (17)
  ) dut (
    .ck   (ck),
    .reset(reset),
    .keys (keys),
    .level(level),
    .pulse(pulse),
    .busy (busy)
  );

  task automatic step(input int n);
    repeat (n) @(posedge ck);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic push(input int c, input logic [3:0] v);
    exp_t e;
    e.cyc = c;
    e.vec = v;
    sb.push_back(e);
  endtask

  // Pulse monitor: any pulse, or a due expectation, is a comparison.
  always @(negedge ck) begin
    exp_t e;
    if (pulse !== 4'b0000 || (sb.size() > 0 && sb[0].cyc == cyc)) begin
      tests++;
      if (sb.size() == 0) begin
        assert (pulse === 4'b0000)
        else begin
          fails++;
          $error("FAIL pulse_unexpected: observed %b at cycle %0d expected 0000", pulse, cyc);
        end
      end else begin
        e = sb.pop_front();
        assert ({cyc, pulse} === {e.cyc, e.vec})
        else begin
          fails++;
          $error("FAIL pulse: observed %b at cycle %0d expected %b at cycle %0d",
                 pulse, cyc, e.vec, e.cyc);
        end
      end
    end
  end

  initial begin
    int t;
    keys  = '0;
    reset = 1'b0;
    step(2);
    check("reset_level", level, 4'b0000);
    check("reset_pulse", pulse, 4'b0000);
    check("reset_busy", {3'b000, busy}, 4'b0000);
    reset = 1'b1;
    step(2);

    // Single press on key 0.
    keys = 4'b0001;
    push(cyc + Lat, 4'b0001);
    step(3);
    check("busy_during_settle", {3'b000, busy}, 4'b0001);
    step(Lat - 2);
    check("press0_level", level, 4'b0001);
    check("press0_idle", {3'b000, busy}, 4'b0000);

    // Key 1 bounces back mid-settle: no commit.
    keys = 4'b0011;
    step(3);
    keys = 4'b0001;
    step(10);
    check("bounce_level", level, 4'b0001);
    check("bounce_idle", {3'b000, busy}, 4'b0000);

    // Pointer left at 1 by the bounce: key 1 is served before key 2.
    keys = 4'b0111;
    push(cyc + Lat, 4'b0010);
    push(cyc + Lat + Gap, 4'b0100);
    step(Lat + Gap + 1);
    check("ptr_kept_level", level, 4'b0111);

    // Reset to bring ptr back to 0.
    reset = 1'b0;
    keys  = 4'b0000;
    step(2);
    check("reset2_level", level, 4'b0000);
    reset = 1'b1;
    step(2);

    // Keys 0 and 2 together: 0 then 2, ptr ends at 3.
    keys = 4'b0101;
    t    = cyc;
    push(t + Lat, 4'b0001);
    push(t + Lat + Gap, 4'b0100);
    step(Lat + Gap + 1);
    check("pair_level", level, 4'b0101);

    // Key 3 served at ptr 3, wrapping ptr to 0.
    keys = 4'b1101;
    push(cyc + Lat, 4'b1000);
    step(Lat + 1);
    check("key3_level", level, 4'b1101);

    // Release 0 and 3 together: key 0 first after wrap, no pulses.
    keys = 4'b0100;
    t    = cyc;
    step(Lat + 1);
    check("wrap_first_release", level, 4'b1100);
    step(Gap);
    check("wrap_second_release", level, 4'b0100);

    // Reset during key 1 settle aborts with no pulse; re-debounced afterwards.
    keys = 4'b0110;
    step(4);
    reset = 1'b0;
    keys  = 4'b0010;
    #1;
    check("abort_level", level, 4'b0000);
    check("abort_pulse", pulse, 4'b0000);
    check("abort_busy", {3'b000, busy}, 4'b0000);
    step(2);
    reset = 1'b1;
    push(cyc + Lat, 4'b0010);
    step(Lat + 2);
    check("redebounce_level", level, 4'b0010);

    step(4);
    tests++;
    assert (sb.size() == 0)
    else begin
      fails++;
      $error("FAIL sb_drained: observed %0d pending expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
